money_dispenser: RTL and testbench

MONEY_DISPENSER -- requirements
Module: money_dispenser

---
 rtl/money_dispenser.sv | 135 +++++++++++++
 tb/tb_money_dispenser.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/money_dispenser.sv
// rtl/money_dispenser.sv - note dispenser FSM: greedy 20/10 EUR payout with ack timeout and sticky fault
// All outputs are registered; they are computed from the next state each cycle.
module money_dispenser #(
    parameter int ACK_TIMEOUT = 15
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       requestValid,
    input  logic [1:0] requestAmount,
    input  logic       dispenseAck,
    output logic       requestReady,
    output logic [4:0] outputNote,
    output logic       done,
    output logic       fault,
    output logic [7:0] notesDispensed
);

    localparam int TW = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT);
    localparam logic [TW-1:0] TIMER_LAST = TW'(ACK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DISPENSE,
        S_GAP,
        S_DONE,
        S_FAULT
    } state_t;

    state_t        state_q, state_d;
    logic [4:0]    remaining_q, remaining_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [4:0]    note_q, note_d;
    logic          ready_q, ready_d;
    logic          done_q, done_d;
    logic          fault_q, fault_d;
    logic [7:0]    count_q, count_d;

    function automatic logic [4:0] select_note(input logic [4:0] rem);
        return (rem >= 5'd20) ? 5'd20 : 5'd10;
    endfunction

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            remaining_q <= '0;
            timer_q     <= '0;
            note_q      <= '0;
            ready_q     <= 1'b1;
            done_q      <= 1'b0;
            fault_q     <= 1'b0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            timer_q     <= timer_d;
            note_q      <= note_d;
            ready_q     <= ready_d;
            done_q      <= done_d;
            fault_q     <= fault_d;
            count_q     <= count_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        timer_d     = timer_q;
        note_d      = note_q;
        ready_d     = 1'b0;
        done_d      = 1'b0;
        fault_d     = fault_q;
        count_d     = count_q;
        case (state_q)
            S_IDLE: begin
                ready_d = 1'b1;
                note_d  = '0;
                if (requestValid && (requestAmount != 2'b00)) begin
                    remaining_d = 5'd10 * {3'b000, requestAmount};
                    note_d      = select_note(remaining_d);
                    timer_d     = '0;
                    ready_d     = 1'b0;
                    state_d     = S_DISPENSE;
                end
            end
            S_DISPENSE: begin
                // An ack on the timeout edge still completes the note normally.
                if (dispenseAck) begin
                    remaining_d = remaining_q - note_q;
                    note_d      = '0;
                    if (count_q != 8'hFF) begin
                        count_d = count_q + 8'd1;
                    end
                    if (remaining_d != 5'd0) begin
                        state_d = S_GAP;
                    end else begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end
                end else if (timer_q == TIMER_LAST) begin
                    state_d = S_FAULT;
                    fault_d = 1'b1;
                    note_d  = '0;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_GAP: begin
                note_d  = select_note(remaining_q);
                timer_d = '0;
                state_d = S_DISPENSE;
            end
            S_DONE: begin
                ready_d = 1'b1;
                note_d  = '0;
                state_d = S_IDLE;
            end
            S_FAULT: begin
                fault_d = 1'b1;
                note_d  = '0;
            end
            default: begin
                state_d = S_IDLE;
                ready_d = 1'b1;
                note_d  = '0;
            end
        endcase
    end

    assign requestReady   = ready_q;
    assign outputNote     = note_q;
    assign done           = done_q;
    assign fault          = fault_q;
    assign notesDispensed = count_q;

endmodule

// File: tb/tb_money_dispenser.sv
// tb/tb_money_dispenser.sv - directed self-checking bench for money_dispenser
module tb_money_dispenser;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       requestValid = 1'b0;
    logic [1:0] requestAmount = 2'b00;
    logic       dispenseAck = 1'b0;
    logic       requestReady;
    logic [4:0] outputNote;
    logic       done;
    logic       fault;
    logic [7:0] notesDispensed;

    int total = 0;
    int bad = 0;

    money_dispenser #(.ACK_TIMEOUT(15)) dut (
        .clock          (clock),
        .reset          (reset),
        .requestValid   (requestValid),
        .requestAmount  (requestAmount),
        .dispenseAck    (dispenseAck),
        .requestReady   (requestReady),
        .outputNote     (outputNote),
        .done           (done),
        .fault          (fault),
        .notesDispensed (notesDispensed)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Inputs idle; reset pulsed low in mid-cycle, checked while held low.
    task automatic test_reset();
        requestValid  = 1'b0;
        requestAmount = 2'b00;
        dispenseAck   = 1'b0;
        tick();
        reset = 1'b0;
        #2;
        total++; if (requestReady !== 1'b1) begin bad++; $display("FAIL reset_ready got=%0b want=1", requestReady); end
        total++; if (outputNote !== 5'd0) begin bad++; $display("FAIL reset_note got=%0d want=0", outputNote); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%0b want=0", done); end
        total++; if (fault !== 1'b0) begin bad++; $display("FAIL reset_fault got=%0b want=0", fault); end
        total++; if (notesDispensed !== 8'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", notesDispensed); end
        reset = 1'b1;
    endtask

    task automatic test_single(input logic [7:0] exp_count);
        requestValid  = 1'b1;
        requestAmount = 2'b01;
        tick();
        total++; if (outputNote !== 5'd10) begin bad++; $display("FAIL single_note got=%0d want=10", outputNote); end
        total++; if (requestReady !== 1'b0) begin bad++; $display("FAIL single_busy got=%0b want=0", requestReady); end
        requestValid = 1'b0;
        dispenseAck  = 1'b1;
        tick();
        dispenseAck = 1'b0;
        total++; if (outputNote !== 5'd0) begin bad++; $display("FAIL single_note_off got=%0d want=0", outputNote); end
        total++; if (done !== 1'b1) begin bad++; $display("FAIL single_done got=%0b want=1", done); end
        total++; if (notesDispensed !== exp_count) begin bad++; $display("FAIL single_count got=%0d want=%0d", notesDispensed, exp_count); end
        tick();
        total++; if (done !== 1'b0) begin bad++; $display("FAIL single_done_end got=%0b want=0", done); end
        total++; if (requestReady !== 1'b1) begin bad++; $display("FAIL single_ready got=%0b want=1", requestReady); end
    endtask

    task automatic test_thirty();
        int dones;
        dones = 0;
        requestValid  = 1'b1;
        requestAmount = 2'b11;
        tick();
        total++; if (outputNote !== 5'd20) begin bad++; $display("FAIL thirty_first got=%0d want=20", outputNote); end
        requestAmount = 2'b01;
        tick();
        total++; if (outputNote !== 5'd20) begin bad++; $display("FAIL thirty_hold got=%0d want=20", outputNote); end
        requestValid = 1'b0;
        dispenseAck  = 1'b1;
        tick();
        dispenseAck = 1'b0;
        if (done === 1'b1) dones++;
        total++; if (outputNote !== 5'd0) begin bad++; $display("FAIL thirty_gap got=%0d want=0", outputNote); end
        total++; if (notesDispensed !== 8'd2) begin bad++; $display("FAIL thirty_count1 got=%0d want=2", notesDispensed); end
        tick();
        if (done === 1'b1) dones++;
        total++; if (outputNote !== 5'd10) begin bad++; $display("FAIL thirty_second got=%0d want=10", outputNote); end
        tick();
        if (done === 1'b1) dones++;
        total++; if (outputNote !== 5'd10) begin bad++; $display("FAIL thirty_hold2 got=%0d want=10", outputNote); end
        dispenseAck = 1'b1;
        tick();
        dispenseAck = 1'b0;
        if (done === 1'b1) dones++;
        total++; if (outputNote !== 5'd0) begin bad++; $display("FAIL thirty_end_note got=%0d want=0", outputNote); end
        total++; if (notesDispensed !== 8'd3) begin bad++; $display("FAIL thirty_count2 got=%0d want=3", notesDispensed); end
        tick();
        if (done === 1'b1) dones++;
        total++; if (dones != 1) begin bad++; $display("FAIL thirty_done_pulses got=%0d want=1", dones); end
        total++; if (requestReady !== 1'b1) begin bad++; $display("FAIL thirty_ready got=%0b want=1", requestReady); end
    endtask

    task automatic test_idle_ignore();
        requestValid  = 1'b1;
        requestAmount = 2'b00;
        tick();
        dispenseAck = 1'b1;
        tick();
        dispenseAck = 1'b0;
        tick();
        dispenseAck = 1'b1;
        tick();
        dispenseAck  = 1'b0;
        requestValid = 1'b0;
        total++; if (requestReady !== 1'b1) begin bad++; $display("FAIL idle_ready got=%0b want=1", requestReady); end
        total++; if (outputNote !== 5'd0) begin bad++; $display("FAIL idle_note got=%0d want=0", outputNote); end
        total++; if (notesDispensed !== 8'd3) begin bad++; $display("FAIL idle_count got=%0d want=3", notesDispensed); end
    endtask

    task automatic test_timeout();
        int n;
        requestValid  = 1'b1;
        requestAmount = 2'b10;
        tick();
        requestValid = 1'b0;
        n = 0;
        while (outputNote === 5'd20 && n < 40) begin
            n++;
            tick();
        end
        total++; if (n != 15) begin bad++; $display("FAIL timeout_cycles got=%0d want=15", n); end
        total++; if (fault !== 1'b1) begin bad++; $display("FAIL timeout_fault got=%0b want=1", fault); end
        total++; if (outputNote !== 5'd0) begin bad++; $display("FAIL timeout_note got=%0d want=0", outputNote); end
        requestValid  = 1'b1;
        requestAmount = 2'b01;
        dispenseAck   = 1'b1;
        repeat (4) tick();
        requestValid = 1'b0;
        dispenseAck  = 1'b0;
        total++; if (fault !== 1'b1) begin bad++; $display("FAIL fault_sticky got=%0b want=1", fault); end
        total++; if (requestReady !== 1'b0) begin bad++; $display("FAIL fault_ready got=%0b want=0", requestReady); end
        total++; if (outputNote !== 5'd0) begin bad++; $display("FAIL fault_note got=%0d want=0", outputNote); end
        total++; if (notesDispensed !== 8'd3) begin bad++; $display("FAIL fault_count got=%0d want=3", notesDispensed); end
    endtask

    task automatic test_reset_mid();
        requestValid  = 1'b1;
        requestAmount = 2'b10;
        tick();
        requestValid = 1'b0;
        total++; if (outputNote !== 5'd20) begin bad++; $display("FAIL mid_note got=%0d want=20", outputNote); end
        #2;
        reset = 1'b0;
        #1;
        total++; if (outputNote !== 5'd0) begin bad++; $display("FAIL mid_async_note got=%0d want=0", outputNote); end
        total++; if (requestReady !== 1'b1) begin bad++; $display("FAIL mid_async_ready got=%0b want=1", requestReady); end
        total++; if (notesDispensed !== 8'd0) begin bad++; $display("FAIL mid_async_count got=%0d want=0", notesDispensed); end
        #1;
        reset = 1'b1;
        tick();
        total++; if (done !== 1'b0) begin bad++; $display("FAIL mid_no_done got=%0b want=0", done); end
        total++; if (requestReady !== 1'b1) begin bad++; $display("FAIL mid_ready got=%0b want=1", requestReady); end
        test_single(8'd1);
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 256; i++) begin
            requestValid  = 1'b1;
            requestAmount = 2'b01;
            tick();
            requestValid = 1'b0;
            dispenseAck  = 1'b1;
            tick();
            dispenseAck = 1'b0;
            tick();
            if (i == 254) begin
                total++; if (notesDispensed !== 8'd255) begin bad++; $display("FAIL sat_reach got=%0d want=255", notesDispensed); end
            end
        end
        total++; if (notesDispensed !== 8'd255) begin bad++; $display("FAIL sat_hold got=%0d want=255", notesDispensed); end
        total++; if (requestReady !== 1'b1) begin bad++; $display("FAIL sat_ready got=%0b want=1", requestReady); end
    endtask

    initial begin
        test_reset();
        test_single(8'd1);
        test_thirty();
        test_idle_ignore();
        test_timeout();
        test_reset();
        test_reset_mid();
        test_reset();
        test_saturate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
